uart_pixel_cmd_ctrl: RTL and testbench

Command sequencer between the UART transceiver and the frame-buffer write/read port of the graphic card. It assembles 6-byte command packets from received bytes, validates them, and executes them against the frame buffer. Supported commands are pixel write, pixel read and full-screen fill. It answers every accepted packet through the transceiver's transmit handshake. It is the only UART client of the frame buffer.

---
 rtl/uart_pixel_cmd_ctrl_if.sv | 29 ++
 rtl/uart_pixel_cmd_ctrl.sv | 155 +++++++++++++++
 tb/tb_uart_pixel_cmd_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pixel_cmd_ctrl_if.sv
// Handshake bundle between the pixel command sequencer, the UART transceiver
// and the frame-buffer port. The master side is the sequencer.
interface uart_pixel_cmd_ctrl_if #(
  parameter int unsigned ADDR_W = 15
);
  logic [7:0]        rx_data;
  logic              rx_done;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_done;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_wdata;
  logic              fb_we;
  logic              fb_re;
  logic              fb_ready;
  logic [7:0]        fb_rdata;
  logic              fb_rvalid;
  logic              busy;

  modport master (
    input  rx_data, rx_done, tx_done, fb_ready, fb_rdata, fb_rvalid,
    output tx_data, tx_wr, fb_addr, fb_wdata, fb_we, fb_re, busy
  );

  modport slave (
    output rx_data, rx_done, tx_done, fb_ready, fb_rdata, fb_rvalid,
    input  tx_data, tx_wr, fb_addr, fb_wdata, fb_we, fb_re, busy
  );
endinterface

// File: rtl/uart_pixel_cmd_ctrl.sv
// Assembles 6-byte UART command packets (sync, op, x, y, colour, xor checksum)
// and executes pixel write / pixel read / screen fill on the frame buffer.
module uart_pixel_cmd_ctrl #(
  parameter int unsigned H_RES   = 160,
  parameter int unsigned V_RES   = 120,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  uart_pixel_cmd_ctrl_if.master bus
);

  localparam int unsigned        TMO_W    = 16;
  localparam logic [7:0]         SYNC     = 8'hA5;
  localparam logic [7:0]         ACK      = 8'h06;
  localparam logic [7:0]         NAK      = 8'h15;
  localparam logic [7:0]         OP_WR    = 8'h01;
  localparam logic [7:0]         OP_RD    = 8'h02;
  localparam logic [7:0]         OP_FILL  = 8'h03;
  localparam logic [ADDR_W-1:0]  FB_LAST  = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, GET_OP, GET_X, GET_Y, GET_C, GET_K, CHECK, WR, RD, RD_WAIT,
    FILL, TX_DATA, TX_DATA_W, TX_RESP, TX_RESP_W
  } state_e;

  state_e            state_q;
  logic [7:0]        op_q, x_q, y_q, c_q, k_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [7:0]        tx_data_q;
  logic              tx_wr_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [7:0]        fb_wdata_q;
  logic              fb_we_q;
  logic              fb_re_q;
  logic              busy_q;

  logic              in_get;
  logic              tmo_hit;
  logic              pkt_ok;
  logic [ADDR_W-1:0] pix_addr;

  assign in_get   = (state_q == GET_OP) || (state_q == GET_X) || (state_q == GET_Y) ||
                    (state_q == GET_C)  || (state_q == GET_K);
  assign tmo_hit  = (tmo_q == TMO_LAST);
  // Fill ignores coordinates; write/read need them on screen.
  assign pkt_ok   = ((op_q ^ x_q ^ y_q ^ c_q) == k_q) &&
                    ((op_q == OP_FILL) ||
                     (((op_q == OP_WR) || (op_q == OP_RD)) &&
                      (32'(x_q) < H_RES) && (32'(y_q) < V_RES)));
  assign pix_addr = ADDR_W'(32'(y_q) * H_RES + 32'(x_q));

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_wr    = tx_wr_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_wdata = fb_wdata_q;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_re    = fb_re_q;
  assign bus.busy     = busy_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      tmo_q      <= '0;
      tx_data_q  <= '0;
      tx_wr_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
      fb_we_q    <= 1'b0;
      fb_re_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // Inter-byte gap counter; a received byte always wins over expiry.
      if (in_get && !bus.rx_done) tmo_q <= tmo_q + TMO_W'(1);
      else                        tmo_q <= '0;

      case (state_q)
        IDLE:    if (bus.rx_done && (bus.rx_data == SYNC)) state_q <= GET_OP;
        GET_OP:  if (bus.rx_done) begin op_q <= bus.rx_data; state_q <= GET_X; end
                 else if (tmo_hit) state_q <= IDLE;
        GET_X:   if (bus.rx_done) begin x_q <= bus.rx_data; state_q <= GET_Y; end
                 else if (tmo_hit) state_q <= IDLE;
        GET_Y:   if (bus.rx_done) begin y_q <= bus.rx_data; state_q <= GET_C; end
                 else if (tmo_hit) state_q <= IDLE;
        GET_C:   if (bus.rx_done) begin c_q <= bus.rx_data; state_q <= GET_K; end
                 else if (tmo_hit) state_q <= IDLE;
        GET_K:   if (bus.rx_done) begin
                   k_q     <= bus.rx_data;
                   busy_q  <= 1'b1;
                   state_q <= CHECK;
                 end else if (tmo_hit) state_q <= IDLE;
        CHECK: begin
          if (!pkt_ok) begin
            tx_data_q <= NAK;
            tx_wr_q   <= 1'b1;
            state_q   <= TX_RESP;
          end else if (op_q == OP_FILL) begin
            fb_addr_q  <= '0;
            fb_wdata_q <= c_q;
            fb_we_q    <= 1'b1;
            state_q    <= FILL;
          end else if (op_q == OP_WR) begin
            fb_addr_q  <= pix_addr;
            fb_wdata_q <= c_q;
            fb_we_q    <= 1'b1;
            state_q    <= WR;
          end else begin
            fb_addr_q <= pix_addr;
            fb_re_q   <= 1'b1;
            state_q   <= RD;
          end
        end
        WR:      if (bus.fb_ready) begin
                   fb_we_q   <= 1'b0;
                   tx_data_q <= ACK;
                   tx_wr_q   <= 1'b1;
                   state_q   <= TX_RESP;
                 end
        RD:      if (bus.fb_ready) begin fb_re_q <= 1'b0; state_q <= RD_WAIT; end
        RD_WAIT: if (bus.fb_rvalid) begin
                   tx_data_q <= bus.fb_rdata;
                   tx_wr_q   <= 1'b1;
                   state_q   <= TX_DATA;
                 end
        FILL:    if (bus.fb_ready) begin
                   if (fb_addr_q == FB_LAST) begin
                     fb_we_q   <= 1'b0;
                     tx_data_q <= ACK;
                     tx_wr_q   <= 1'b1;
                     state_q   <= TX_RESP;
                   end else begin
                     fb_addr_q <= fb_addr_q + ADDR_W'(1);
                   end
                 end
        TX_DATA:   begin tx_wr_q <= 1'b0; state_q <= TX_DATA_W; end
        TX_DATA_W: if (bus.tx_done) begin
                     tx_data_q <= ACK;
                     tx_wr_q   <= 1'b1;
                     state_q   <= TX_RESP;
                   end
        TX_RESP:   begin tx_wr_q <= 1'b0; state_q <= TX_RESP_W; end
        TX_RESP_W: if (bus.tx_done) begin busy_q <= 1'b0; state_q <= IDLE; end
        default:   state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pixel_cmd_ctrl.sv
// Directed bench for uart_pixel_cmd_ctrl: behavioural UART and frame-buffer
// responders, per-scenario tasks with hand-computed expectations.
module tb_uart_pixel_cmd_ctrl;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned TMO    = 300;
  localparam int unsigned NPIX   = 160 * 120;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_pixel_cmd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_pixel_cmd_ctrl #(
    .H_RES(160), .V_RES(120), .ADDR_W(ADDR_W), .TIMEOUT(TMO)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         rd_acc = -100;
  int         tx_cyc = -100;
  bit         tog = 1'b0;
  bit         tx_pend = 1'b0;
  bit         tx_prev_wr = 1'b0;
  int         both_err = 0;
  int         len_err = 0;
  int         ovl_err = 0;
  int         rd_cnt = 0;
  int         rd_addr = -1;
  int         we_first = -1;
  int         tx_first = -1;
  int         rx_cyc = 0;
  int         wr_addr[$];
  logic [7:0] wr_data[$];
  logic [7:0] tx_log[$];

  // Responders and monitor, all at the falling edge; acceptance is judged
  // on the fb_ready value that the next rising edge will see.
  always @(negedge clk) begin
    cyc++;
    bus.fb_ready  = tog ? ~bus.fb_ready : 1'b1;
    bus.fb_rvalid = (cyc == rd_acc + 3);
    bus.fb_rdata  = 8'h5A;
    bus.tx_done   = (cyc == tx_cyc + 3);
    if (rst_n) begin
      if (bus.fb_we && bus.fb_re) both_err++;
      if (bus.fb_we && bus.fb_ready) begin
        if (wr_addr.size() == 0) we_first = cyc;
        wr_addr.push_back(int'(bus.fb_addr));
        wr_data.push_back(bus.fb_wdata);
      end
      if (bus.fb_re && bus.fb_ready) begin
        rd_cnt++;
        rd_addr = int'(bus.fb_addr);
        rd_acc  = cyc;
      end
      if (bus.tx_wr) begin
        if (tx_prev_wr) len_err++;
        if (tx_pend) ovl_err++;
        if (tx_log.size() == 0) tx_first = cyc;
        tx_log.push_back(bus.tx_data);
        tx_cyc  = cyc;
        tx_pend = 1'b1;
      end
      tx_prev_wr = bus.tx_wr;
      if (bus.tx_done) tx_pend = 1'b0;
    end
  end

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    tx_log.delete();
    rd_cnt   = 0;
    rd_addr  = -1;
    we_first = -1;
    tx_first = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    rx_cyc = cyc;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, b1, b2, b3, b4, b5);
    send_byte(b0); send_byte(b1); send_byte(b2);
    send_byte(b3); send_byte(b4); send_byte(b5);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int i = 0;
    while (tx_log.size() < n && i < budget) begin @(posedge clk); #1; i++; end
    checks++;
    if (tx_log.size() < n) begin
      errors++;
      $display("FAIL wait_tx got %0d bytes required %0d", tx_log.size(), n);
    end
    i = 0;
    while (bus.busy && i < 50) begin @(posedge clk); #1; i++; end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.tx_wr, bus.tx_data, bus.fb_we, bus.fb_re, bus.busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_ctl got %0h required 0",
               {bus.tx_wr, bus.tx_data, bus.fb_we, bus.fb_re, bus.busy});
    end
    checks++;
    if ({bus.fb_addr, bus.fb_wdata} !== 23'h0) begin
      errors++;
      $display("FAIL reset_fb got %0h required 0", {bus.fb_addr, bus.fb_wdata});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write();
    clear_logs();
    send_pkt(8'hA5, 8'h01, 8'h05, 8'h03, 8'h3C, 8'h3B);
    wait_tx(1, 200);
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] != 485 || wr_data[0] !== 8'h3C) begin
      errors++;
      $display("FAIL write_fb got n=%0d addr=%0d data=%0h required n=1 addr=485 data=3c",
               wr_addr.size(), wr_addr.size() ? wr_addr[0] : -1,
               wr_data.size() ? wr_data[0] : 8'hxx);
    end
    checks++;
    if (tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
      errors++;
      $display("FAIL write_tx got n=%0d first=%0h required n=1 06",
               tx_log.size(), tx_log.size() ? tx_log[0] : 8'hxx);
    end
    checks++;
    if (we_first - rx_cyc != 2) begin
      errors++;
      $display("FAIL write_latency got %0d required 2", we_first - rx_cyc);
    end
  endtask

  task automatic test_read();
    clear_logs();
    send_pkt(8'hA5, 8'h02, 8'h9F, 8'h77, 8'h00, 8'hEA);
    wait_tx(2, 200);
    checks++;
    if (rd_cnt != 1 || rd_addr != 19199 || wr_addr.size() != 0) begin
      errors++;
      $display("FAIL read_fb got rd=%0d addr=%0d wr=%0d required rd=1 addr=19199 wr=0",
               rd_cnt, rd_addr, wr_addr.size());
    end
    checks++;
    if (tx_log.size() != 2 || tx_log[0] !== 8'h5A || tx_log[1] !== 8'h06) begin
      errors++;
      $display("FAIL read_tx got n=%0d required 5a 06", tx_log.size());
    end
  endtask

  task automatic test_fill();
    int bad = 0;
    clear_logs();
    tog = 1'b1;
    send_pkt(8'hA5, 8'h03, 8'h00, 8'h00, 8'hFF, 8'hFC);
    wait_tx(1, 50000);
    tog = 1'b0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] != i || wr_data[i] !== 8'hFF) bad++;
    checks++;
    if (wr_addr.size() != NPIX || bad != 0) begin
      errors++;
      $display("FAIL fill_fb got n=%0d bad=%0d required n=%0d bad=0",
               wr_addr.size(), bad, NPIX);
    end
    checks++;
    if (tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
      errors++;
      $display("FAIL fill_tx got n=%0d required 1 ack", tx_log.size());
    end
  endtask

  task automatic test_errors();
    clear_logs();
    send_pkt(8'hA5, 8'h01, 8'hA0, 8'h00, 8'h11, 8'hB0);
    wait_tx(1, 200);
    checks++;
    if (tx_log.size() != 1 || tx_log[0] !== 8'h15 || wr_addr.size() != 0 || rd_cnt != 0) begin
      errors++;
      $display("FAIL nak_x got tx_n=%0d wr=%0d rd=%0d required one 15, no access",
               tx_log.size(), wr_addr.size(), rd_cnt);
    end
    checks++;
    if (tx_first - rx_cyc != 2) begin
      errors++;
      $display("FAIL nak_latency got %0d required 2", tx_first - rx_cyc);
    end
    clear_logs();
    send_pkt(8'hA5, 8'h01, 8'h05, 8'h03, 8'h3C, 8'h00);
    wait_tx(1, 200);
    checks++;
    if (tx_log.size() != 1 || tx_log[0] !== 8'h15 || wr_addr.size() != 0) begin
      errors++;
      $display("FAIL nak_k got tx_n=%0d wr=%0d required one 15, no write",
               tx_log.size(), wr_addr.size());
    end
    clear_logs();
    send_pkt(8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h04);
    wait_tx(1, 200);
    checks++;
    if (tx_log.size() != 1 || tx_log[0] !== 8'h15 || wr_addr.size() != 0 || rd_cnt != 0) begin
      errors++;
      $display("FAIL nak_op got tx_n=%0d wr=%0d rd=%0d required one 15",
               tx_log.size(), wr_addr.size(), rd_cnt);
    end
    clear_logs();
    send_pkt(8'hA5, 8'h02, 8'h00, 8'h78, 8'h00, 8'h7A);
    wait_tx(1, 200);
    checks++;
    if (tx_log.size() != 1 || tx_log[0] !== 8'h15 || rd_cnt != 0) begin
      errors++;
      $display("FAIL nak_y got tx_n=%0d rd=%0d required one 15, no read",
               tx_log.size(), rd_cnt);
    end
  endtask

  task automatic test_sync_in_data();
    clear_logs();
    send_pkt(8'hA5, 8'h01, 8'h00, 8'h00, 8'hA5, 8'hA4);
    wait_tx(1, 200);
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] != 0 || wr_data[0] !== 8'hA5 ||
        tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
      errors++;
      $display("FAIL sync_data got wr_n=%0d tx_n=%0d required one write a5 at 0, ack",
               wr_addr.size(), tx_log.size());
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05);
    repeat (TMO + 10) @(posedge clk);
    send_pkt(8'hA5, 8'h01, 8'h05, 8'h03, 8'h3C, 8'h3B);
    wait_tx(1, 200);
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] != 485 || tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
      errors++;
      $display("FAIL timeout got wr_n=%0d tx_n=%0d required one write at 485, one ack",
               wr_addr.size(), tx_log.size());
    end
    clear_logs();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05);
    repeat (TMO - 20) @(posedge clk);
    send_byte(8'h03); send_byte(8'h3C); send_byte(8'h3B);
    wait_tx(1, 200);
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] != 485) begin
      errors++;
      $display("FAIL slow_gap got wr_n=%0d required one write at 485", wr_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    send_pkt(8'hA5, 8'h02, 8'h9F, 8'h77, 8'h00, 8'hEA);
    send_byte(8'hA5);
    wait_tx(2, 200);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h03);
    send_byte(8'h3C); send_byte(8'h3B);
    repeat (20) @(posedge clk);
    checks++;
    if (wr_addr.size() != 0 || tx_log.size() != 2) begin
      errors++;
      $display("FAIL busy_drop got wr_n=%0d tx_n=%0d required 0 and 2",
               wr_addr.size(), tx_log.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    int i = 0;
    clear_logs();
    send_pkt(8'hA5, 8'h03, 8'h00, 8'h00, 8'h42, 8'h41);
    while (wr_addr.size() < 100 && i < 500) begin @(posedge clk); #1; i++; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.fb_we !== 1'b0 || bus.fb_addr !== '0) begin
      errors++;
      $display("FAIL mid_reset got we=%0b addr=%0d required 0 0", bus.fb_we, bus.fb_addr);
    end
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (tx_log.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_tx got tx_n=%0d busy=%0b required 0 0", tx_log.size(), bus.busy);
    end
    clear_logs();
    send_pkt(8'hA5, 8'h01, 8'h05, 8'h03, 8'h3C, 8'h3B);
    wait_tx(1, 200);
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] != 485 || tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
      errors++;
      $display("FAIL after_reset got wr_n=%0d tx_n=%0d required one write at 485, ack",
               wr_addr.size(), tx_log.size());
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (both_err != 0 || len_err != 0 || ovl_err != 0) begin
      errors++;
      $display("FAIL protocol got both=%0d len=%0d overlap=%0d required 0 0 0",
               both_err, len_err, ovl_err);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fill();
    test_errors();
    test_sync_in_data();
    test_timeout();
    test_back_to_back();
    test_reset_mid_fill();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
